pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the five-stage pipelined CPU.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC write enable.
- Resolves three hazard classes:
  - load-use hazards detected in ID,
  - taken branches resolved in MEM,
  - multi-cycle data-memory accesses in MEM.
- A timeout FSM supervises data-memory accesses and latches a fault if memory never responds.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before entering FAULT; legal range 1..255.
- REG_W, 5: register-index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_rn  input  REG_W  first source register of the instruction in ID
- id_rm  input  REG_W  second source register of the instruction in ID
- id_uses_rn  input  1  ID instruction reads id_rn
- id_uses_rm  input  1  ID instruction reads id_rm
- ex_mem_read  input  1  EX instruction is a load
- ex_rd  input  REG_W  destination register of the EX instruction
- br_taken_mem  input  1  branch in MEM is taken
- mem_req  input  1  MEM instruction accesses data memory this cycle
- mem_ready  input  1  data memory completes the access this cycle
- pc_en  output  1  PC write enable
- if_id_en  output  1  IF/ID register enable
- id_ex_en  output  1  ID/EX register enable
- ex_mem_en  output  1  EX/MEM register enable
- mem_wb_en  output  1  MEM/WB register enable
- if_id_flush  output  1  load NOP into IF/ID
- id_ex_flush  output  1  load NOP into ID/EX
- ex_mem_flush  output  1  load NOP into EX/MEM
- mem_wb_flush  output  1  load NOP into MEM/WB
- mem_fault  output  1  sticky timeout flag
- state  output  2  encoding: RUN=0, MEM_WAIT=1, FAULT=2

Behaviour:
- Reset, asynchronous:
  - state=RUN, wait counter=0, mem_fault=0.
  - While reset is high, all *_en=0 and all *_flush=1, overriding every other output.
- All enable/flush outputs are combinational from state and the current-cycle inputs (zero latency).
- The registered state and counter update on the rising edge of clk.
- Hazard terms:
  - memstall = mem_req & !mem_ready, with state RUN or MEM_WAIT.
  - loaduse = ex_mem_read & ex_rd!=31 & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)). X31 is XZR and never causes a hazard.
- Priority, highest first: FAULT > memstall > br_taken_mem > loaduse > normal.
- FAULT:
  - All *_en=0 and all *_flush=0; the pipeline is frozen.
  - mem_fault=1.
  - Exited only by reset.
- memstall:
  - pc_en, if_id_en, id_ex_en and ex_mem_en are 0.
  - mem_wb_en=1 with mem_wb_flush=1, so a bubble enters WB.
  - br_taken_mem and loaduse are ignored this cycle.
- br_taken_mem, no memstall:
  - All enables are 1.
  - if_id_flush, id_ex_flush and ex_mem_flush are 1; mem_wb_flush=0.
  - Exactly one cycle, with no residual stall.
- loaduse, no higher condition:
  - pc_en=0 and if_id_en=0.
  - id_ex_en=1 with id_ex_flush=1 (bubble).
  - ex_mem_en and mem_wb_en are 1.
  - Exactly one cycle; the load then advances to MEM and loaduse deasserts by construction.
- Normal: all enables are 1 and all flushes are 0.
- FSM transitions:
  - RUN -> MEM_WAIT when memstall; the counter loads 1.
  - MEM_WAIT -> MEM_WAIT while memstall; the counter increments.
  - MEM_WAIT -> RUN on mem_ready, or when mem_req drops; the counter clears.
  - MEM_WAIT -> FAULT when memstall and counter==MEM_TIMEOUT. The transition is taken on that edge; outputs in that cycle are still the memstall outputs.
  - A single-cycle access (mem_req & mem_ready in RUN) stays in RUN with no stall.
- Counter width is clog2(MEM_TIMEOUT+1); it never wraps, because FAULT is entered first.
- Reset mid-stall returns to RUN immediately, asynchronously, regardless of state.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- When defined, the block adds outputs stall_cycles[31:0] and flush_events[31:0]. Both reset to 0 and both saturate at 0xFFFFFFFF.
  - stall_cycles counts every cycle with memstall or loaduse active.
  - flush_events counts every cycle in which the br_taken_mem flush is applied.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1 -> for one cycle pc_en=0, if_id_en=0, id_ex_flush=1; the next cycle (ex_mem_read=0) all enables are 1.
- XZR/no-use: ex_rd=31=id_rn, or id_uses_rn=0 with matching index -> no stall; all enables 1, all flushes 0.
- Branch: br_taken_mem=1 for one cycle -> if_id_flush, id_ex_flush and ex_mem_flush are 1 that cycle, all enables are 1, mem_wb_flush=0, and the next cycle is clean.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> state=1 for 3 cycles; front enables are 0 and mem_wb_flush=1 on each of those 3 cycles; state=0 after ready. If a simultaneous br_taken_mem is held, no flush is applied until the wait ends.
- Timeout: MEM_TIMEOUT=4 with mem_ready held 0 -> state=2 and mem_fault=1 after the 5th stalled edge; all outputs are 0 thereafter. Asserting reset mid-FAULT clears state and flag immediately, without waiting for a clock edge.
- Perf (macro defined): 1 load-use, 1 branch and a 3-cycle memory wait -> stall_cycles=4, flush_events=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller with memory-timeout FSM for a five-stage pipeline.
// Optional event counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken_mem,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_fault,
    output logic [1:0]       state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
`endif
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);
    localparam logic [REG_W-1:0] XZR = REG_W'(31);

    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FAULT = 2'd2} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          mem_fault_q;
    logic          fault, memstall, loaduse;
    logic [4:0]    en;
    logic [3:0]    fl;

    assign fault    = state_q == FAULT;
    assign memstall = mem_req & ~mem_ready & ~fault;
    assign loaduse  = ex_mem_read & (ex_rd != XZR) &
                      ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

    always_comb begin
        en = 5'b11111;
        fl = 4'b0000;
        if (reset) begin
            en = 5'b00000;
            fl = 4'b1111;
        end else if (fault) begin
            en = 5'b00000;
        end else if (memstall) begin
            en = 5'b00001;
            fl = 4'b0001;
        end else if (br_taken_mem) begin
            fl = 4'b1110;
        end else if (loaduse) begin
            en = 5'b00111;
            fl = 4'b0100;
        end
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
    assign {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = fl;
    assign mem_fault = mem_fault_q;
    assign state     = state_q;

    // The counter holds the number of stalled edges already spent in MEM_WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: if (memstall) begin
                    state_q <= MEM_WAIT;
                    cnt_q   <= CW'(1);
                end
                MEM_WAIT: if (!memstall) begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end else if (cnt_q == TMO) begin
                    state_q     <= FAULT;
                    mem_fault_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: mem_fault_q <= 1'b1;
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((memstall | (loaduse & ~fault)) && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (br_taken_mem & ~memstall & ~fault && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl with MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;
    localparam int TMO = 4;

    logic       clk = 1'b0, reset = 1'b1;
    logic [4:0] id_rn = '0, id_rm = '0, ex_rd = '0;
    logic       id_uses_rn = 1'b0, id_uses_rm = 1'b0, ex_mem_read = 1'b0;
    logic       br_taken_mem = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_fault;
    logic [1:0] state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events;
    int          exp_stall = 0, exp_flush = 0;
`endif

    int          n_cmp = 0, n_err = 0;
    logic [1:0]  ms = 2'd0;
    int          mcnt = 0;
    logic [11:0] sb[$];
    logic [11:0] outv;

    localparam logic [11:0] RST_V = 12'b00000_1111_0_00;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken_mem(br_taken_mem),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mem_fault(mem_fault), .state(state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    assign outv = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_fault, state};

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Returns {en[4:0], flush[3:0], mem_fault, state[1:0], stall_event, flush_event}.
    function automatic logic [13:0] model(input logic [4:0] rn, rm, input logic urn, urm, emr,
                                          input logic [4:0] erd, input logic br, req, rdy);
        logic f, mst, lu;
        f   = ms == 2'd2;
        mst = ~f & req & ~rdy;
        lu  = emr & (erd != 5'd31) & ((urn & rn == erd) | (urm & rm == erd));
        if (f)        return {5'b00000, 4'b0000, 1'b1, ms, 2'b00};
        if (mst)      return {5'b00001, 4'b0001, 1'b0, ms, 2'b10};
        if (br)       return {5'b11111, 4'b1110, 1'b0, ms, lu, 1'b1};
        if (lu)       return {5'b00111, 4'b0100, 1'b0, ms, 2'b10};
        return {5'b11111, 4'b0000, 1'b0, ms, 2'b00};
    endfunction

    task automatic step(input string tag, input logic [4:0] rn, rm, input logic urn, urm, emr,
                        input logic [4:0] erd, input logic br, req, rdy);
        logic [13:0] m;
        logic        mst;
        id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
        ex_mem_read = emr; ex_rd = erd; br_taken_mem = br; mem_req = req; mem_ready = rdy;
        m = model(rn, rm, urn, urm, emr, erd, br, req, rdy);
        sb.push_back(m[13:2]);
        #1;
        chk(tag, outv, sb.pop_front());
        @(posedge clk);
        mst = (ms != 2'd2) & req & ~rdy;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        exp_stall += int'(m[1]);
        exp_flush += int'(m[0]);
`endif
        if (ms == 2'd0 && mst) begin
            ms = 2'd1; mcnt = 1;
        end else if (ms == 2'd1) begin
            if (!mst) begin ms = 2'd0; mcnt = 0; end
            else if (mcnt == TMO) ms = 2'd2;
            else mcnt++;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        ms = 2'd0; mcnt = 0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        exp_stall = 0; exp_flush = 0;
`endif
    endtask

    initial begin
        #2 chk("reset_hold", outv, RST_V);
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rn = 5'd3; id_uses_rn = 1'b1; br_taken_mem = 1'b1;
        #1 chk("reset_override", outv, RST_V);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step("normal",        5'd1,  5'd2, 1, 1, 0, 5'd1,  0, 0, 0);
        step("loaduse_rn",    5'd3,  5'd0, 1, 0, 1, 5'd3,  0, 0, 0);
        step("after_lu",      5'd3,  5'd0, 1, 0, 0, 5'd3,  0, 0, 0);
        step("loaduse_rm",    5'd0,  5'd7, 0, 1, 1, 5'd7,  0, 0, 0);
        step("xzr",           5'd31, 5'd0, 1, 0, 1, 5'd31, 0, 0, 0);
        step("no_use",        5'd3,  5'd3, 0, 0, 1, 5'd3,  0, 0, 0);
        step("branch",        5'd0,  5'd0, 0, 0, 0, 5'd0,  1, 0, 0);
        step("after_br",      5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 0, 0);
        step("br_over_lu",    5'd4,  5'd0, 1, 0, 1, 5'd4,  1, 0, 0);
        step("single_access", 5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 1, 1);
        for (int i = 0; i < 3; i++)
            step($sformatf("wait_br_%0d", i), 5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 1, 0);
        step("ready_br",      5'd0,  5'd0, 0, 0, 0, 5'd0,  1, 1, 1);
        step("after_wait",    5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 0, 0);
        step("req_stall",     5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 1, 0);
        step("req_drop",      5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 0, 0);
        step("back_run",      5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 0, 0);
        for (int i = 0; i < TMO + 1; i++)
            step($sformatf("timeout_%0d", i), 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        step("fault_lu",      5'd3,  5'd0, 1, 0, 1, 5'd3,  0, 0, 0);
        step("fault_br",      5'd0,  5'd0, 0, 0, 0, 5'd0,  1, 1, 1);
        step("fault_idle",    5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 0, 0);
        #2 reset = 1'b1;
        #1 chk("async_reset", outv, RST_V);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step("post_reset",    5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 0, 0);
        for (int i = 0; i < TMO; i++)
            step($sformatf("long_wait_%0d", i), 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        step("long_ready",    5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 1, 1);
        step("long_after",    5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 0, 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step("perf_lu",       5'd3,  5'd0, 1, 0, 1, 5'd3,  0, 0, 0);
        step("perf_br",       5'd0,  5'd0, 0, 0, 0, 5'd0,  1, 0, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("perf_wait_%0d", i), 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        step("perf_ready",    5'd0,  5'd0, 0, 0, 0, 5'd0,  0, 1, 1);
        n_cmp++;
        assert (stall_cycles === 32'(exp_stall) && stall_cycles === 32'd4) else begin
            n_err++;
            $error("FAIL stall_cycles: observed %0d expected 4", stall_cycles);
        end
        n_cmp++;
        assert (flush_events === 32'(exp_flush) && flush_events === 32'd1) else begin
            n_err++;
            $error("FAIL flush_events: observed %0d expected 1", flush_events);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
